// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one imem read at a time, buffers the returned
// instruction and its address, and hands it to DEC under hazard-unit control.
module instruction_fetch_unit #(
  parameter int                         DATA_WIDTH    = 32,
  parameter int                         ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Enable,
  input  logic                     i_Stall,
  input  logic                     i_Smash,
  input  logic                     i_Load,
  input  logic [ADDRESS_WIDTH-1:0] i_Load_Address,
  output logic                     o_Mem_Read,
  output logic [ADDRESS_WIDTH-1:0] o_Mem_Address,
  input  logic                     i_Mem_Valid,
  input  logic [DATA_WIDTH-1:0]    i_Mem_Data,
  output logic                     o_Done,
  output logic                     o_Valid,
  output logic [DATA_WIDTH-1:0]    o_Instruction,
  output logic [ADDRESS_WIDTH-1:0] o_PC,
  output logic [ADDRESS_WIDTH-1:0] o_PC_Plus4,
  output logic [31:0]              o_Fetch_Count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] pc;
  logic                     consume;
  logic                     capture;

  // A response that arrives while disabled is dropped, so it never lands in the buffer.
  assign consume = (state == READY) && !i_Stall && i_Enable;
  assign capture = (state == FETCH) && i_Mem_Valid && i_Enable;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_Enable) state_next = FETCH;
      FETCH:   if (i_Mem_Valid) state_next = i_Enable ? READY : IDLE;
      READY: begin
        if (!i_Enable)     state_next = IDLE;
        else if (!i_Stall) state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is asynchronous, so
  // an in-flight request is dropped the instant i_Reset_n falls.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      o_Instruction <= '0;
      o_PC          <= '0;
      o_Fetch_Count <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        o_Instruction <= i_Mem_Data;
        o_PC          <= pc;
      end
      if (consume) begin
        pc            <= i_Load ? i_Load_Address : pc + ADDRESS_WIDTH'(4);
        o_Fetch_Count <= o_Fetch_Count + 32'd1;
      end
    end
  end

  // The PC only moves on consumption, so the address is stable for the whole request.
  assign o_Mem_Read    = (state == FETCH);
  assign o_Mem_Address = {pc[ADDRESS_WIDTH-1:2], 2'b00};
  assign o_Done        = (state == READY);
  assign o_Valid       = (state == READY) && !i_Smash;
  assign o_PC_Plus4    = o_PC + ADDRESS_WIDTH'(4);

endmodule
